// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter.
// On tx_start it sends a full frame: a 9 ms leader, a 4.5 ms space, 32 bits sent
// LSB-first, and a stop burst. On rpt_start it sends the short repeat code.
// It drives an active-low envelope (inf_out) that can loop straight into the
// receiver, and a carrier-modulated LED drive (ir_led).
// Handshake: tx_start/rpt_start are one-cycle strobes taken only while idle.
// Strobes seen while busy are dropped, not queued. busy covers the cycle after
// acceptance through the last gap cycle, and tx_done marks the cycle after that.
module nec_ir_tx #(
   parameter int CNT_9MS    = 450_000,
   parameter int CNT_4_5MS  = 225_000,
   parameter int CNT_2_25MS = 112_500,
   parameter int CNT_0_56MS = 28_000,
   parameter int CNT_1_69MS = 84_500,
   parameter int CNT_GAP    = 2_000_000,
   parameter int CAR_HALF   = 658
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       tx_start,
   input  logic       rpt_start,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   output logic       inf_out,
   output logic       ir_led,
   output logic       busy,
   output logic       tx_done
);

   // The segment counter must hold the longest segment minus one.
   localparam int MAX_A   = (CNT_9MS > CNT_4_5MS) ? CNT_9MS : CNT_4_5MS;
   localparam int MAX_B   = (CNT_2_25MS > CNT_0_56MS) ? CNT_2_25MS : CNT_0_56MS;
   localparam int MAX_C   = (CNT_1_69MS > CNT_GAP) ? CNT_1_69MS : CNT_GAP;
   localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int SEG_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int CNT_W   = $clog2(SEG_MAX + 1);
   localparam int CAR_W   = $clog2(CAR_HALF + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEAD_L = 3'd1,
      LEAD_H = 3'd2,
      BIT_L  = 3'd3,
      BIT_H  = 3'd4,
      STOP_L = 3'd5,
      GAP    = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         bit_cnt_q, bit_cnt_d;
   logic [31:0]        shift_q, shift_d;
   logic               rpt_q, rpt_d;
   logic               inf_out_q, inf_out_d;
   logic               ir_led_q, ir_led_d;
   logic               busy_q, busy_d;
   logic               tx_done_q, tx_done_d;
   logic [CAR_W-1:0]   car_cnt_q, car_cnt_d;
   logic               phase_q, phase_d;
   logic [CNT_W-1:0]   seg_last;
   logic               seg_done;

   // Last count value of the current segment; in BIT_H the length is set by the bit being sent.
   always_comb begin
      seg_last = '0;
      case (state_q)
         LEAD_L:  seg_last = CNT_W'(CNT_9MS - 1);
         LEAD_H:  seg_last = rpt_q ? CNT_W'(CNT_2_25MS - 1) : CNT_W'(CNT_4_5MS - 1);
         BIT_L:   seg_last = CNT_W'(CNT_0_56MS - 1);
         BIT_H:   seg_last = shift_q[0] ? CNT_W'(CNT_1_69MS - 1) : CNT_W'(CNT_0_56MS - 1);
         STOP_L:  seg_last = CNT_W'(CNT_0_56MS - 1);
         GAP:     seg_last = CNT_W'(CNT_GAP - 1);
         default: seg_last = '0;
      endcase
   end

   assign seg_done = (cnt_q == seg_last);

   // Next state: accept strobes in IDLE and step through the segments as each one expires.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rpt_d     = rpt_q;
      tx_done_d = 1'b0;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (tx_start) begin
            state_d = LEAD_L;
            rpt_d   = 1'b0;
            shift_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
         end else if (rpt_start) begin
            state_d = LEAD_L;
            rpt_d   = 1'b1;
         end
      end else if (!seg_done) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
         case (state_q)
            LEAD_L: state_d = LEAD_H;
            LEAD_H: begin
               bit_cnt_d = '0;
               state_d   = rpt_q ? STOP_L : BIT_L;
            end
            BIT_L:  state_d = BIT_H;
            BIT_H: begin
               shift_d   = {1'b0, shift_q[31:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               state_d   = (bit_cnt_q == 6'd31) ? STOP_L : BIT_L;
            end
            STOP_L: state_d = GAP;
            GAP: begin
               state_d   = IDLE;
               tx_done_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs follow the next state, so the first LEAD_L cycle already shows the burst.
   // The carrier phase sits at 1 through spaces, so each burst starts with the LED on.
   always_comb begin
      inf_out_d = !(state_d inside {LEAD_L, BIT_L, STOP_L});
      busy_d    = (state_d != IDLE);
      car_cnt_d = '0;
      phase_d   = 1'b1;
      if (!inf_out_d && !inf_out_q) begin
         if (car_cnt_q == CAR_W'(CAR_HALF - 1)) begin
            car_cnt_d = '0;
            phase_d   = ~phase_q;
         end else begin
            car_cnt_d = car_cnt_q + 1'b1;
            phase_d   = phase_q;
         end
      end
      ir_led_d = ~inf_out_d & phase_d;
   end

   // State and output registers; reset forces the idle envelope and LED off immediately.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rpt_q     <= 1'b0;
         inf_out_q <= 1'b1;
         ir_led_q  <= 1'b0;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
         car_cnt_q <= '0;
         phase_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rpt_q     <= rpt_d;
         inf_out_q <= inf_out_d;
         ir_led_q  <= ir_led_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
         car_cnt_q <= car_cnt_d;
         phase_q   <= phase_d;
      end
   end

   assign inf_out = inf_out_q;
   assign ir_led  = ir_led_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule
